// File: rtl/float_to_fixed.sv
// float_to_fixed
//   IEEE-754 single-precision to 16-bit signed fixed point, Q(15-FRAC_BITS).FRAC_BITS.
//   Three registered stages:
//     S1 unpack/classify  -> S2 align mantissa (+1 guard bit)  -> S3 round/saturate/negate
//   All stages advance together when the output slot is empty or being taken.
//   A stalled pipeline holds every stage, including the output registers.
//
// Parameters
//   FRAC_BITS             fractional bits of the result (0..15)
// Ports
//   clk                   rising-edge clock
//   rst                   synchronous active-high reset (clears valids and output)
//   s_axis_a_tvalid/ready input handshake; tready is combinational
//   s_axis_a_tdata        32-bit float sample
//   m_axis_result_tvalid/ready output handshake
//   m_axis_result_tdata   16-bit two's-complement result
//   m_axis_result_tuser   1 = saturated or NaN input
// Configuration
//   F2X_ROUND_EN          defined: round to nearest, ties away from zero
//                         undefined: truncate magnitude toward zero
module float_to_fixed #(
    parameter int FRAC_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_axis_a_tvalid,
    output logic        s_axis_a_tready,
    input  logic [31:0] s_axis_a_tdata,
    output logic        m_axis_result_tvalid,
    input  logic        m_axis_result_tready,
    output logic [15:0] m_axis_result_tdata,
    output logic        m_axis_result_tuser
);

    localparam int STAGES = 3;

`ifdef F2X_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;   // hidden bit included
        logic        nan;
        logic        inf;
        logic        zero;   // zero or denormal: both map to 0
    } s1_t;

    typedef struct packed {
        logic        sign;
        logic        nan;
        logic        ovf;    // infinity or magnitude certainly >= 2^16 LSB
        logic [16:0] mag_g;  // magnitude in LSB units with one guard bit at [0]
    } s2_t;

    logic [STAGES:1] vld_pipe;
    logic            adv;
    logic            in_fire;

    s1_t s1, s1_d;
    s2_t s2, s2_d;

    logic signed [10:0] k;    // exponent - 127 + FRAC_BITS
    logic signed [10:0] rsh;  // right shift of 24-bit mantissa that leaves one guard bit
    logic               rbit;
    logic [16:0]        rmag;
    logic [15:0]        out_data;
    logic               out_user;

    assign adv                  = !vld_pipe[STAGES] || m_axis_result_tready;
    assign s_axis_a_tready      = adv;
    assign in_fire              = s_axis_a_tvalid && adv;
    assign m_axis_result_tvalid = vld_pipe[STAGES];

    // S1: unpack and classify
    always_comb begin
        s1_d      = '0;
        s1_d.sign = s_axis_a_tdata[31];
        s1_d.exp  = s_axis_a_tdata[30:23];
        s1_d.mant = {1'b1, s_axis_a_tdata[22:0]};
        s1_d.nan  = (s_axis_a_tdata[30:23] == 8'hFF) && (s_axis_a_tdata[22:0] != '0);
        s1_d.inf  = (s_axis_a_tdata[30:23] == 8'hFF) && (s_axis_a_tdata[22:0] == '0);
        s1_d.zero = (s_axis_a_tdata[30:23] == 8'h00);
    end

    // S2: value in LSB units is mant * 2^(k-23). Keeping one extra bit means
    // shifting right by 22-k. k <= 15 bounds the result to 17 bits; anything
    // larger is >= 2^16 LSB and saturates regardless of sign or rounding.
    always_comb begin
        k         = $signed({3'b000, s1.exp}) - 11'sd127 + 11'(FRAC_BITS);
        rsh       = 11'sd22 - k;
        s2_d      = '0;
        s2_d.sign = s1.sign;
        s2_d.nan  = s1.nan;
        if (s1.nan || s1.zero) begin
            s2_d.mag_g = '0;
        end else if (s1.inf || k > 11'sd15) begin
            s2_d.ovf = 1'b1;
        end else if (rsh > 11'sd24) begin
            // below a quarter LSB: nothing survives, not even the guard bit
            s2_d.mag_g = '0;
        end else begin
            s2_d.mag_g = 17'(s1.mant >> rsh[4:0]);
        end
    end

    // S3: round on magnitude (a set guard bit means >= .5, so ties go away
    // from zero), then saturate on the rounded value, then apply sign.
    always_comb begin
        rbit     = ROUND_EN & s2.mag_g[0];
        rmag     = {1'b0, s2.mag_g[16:1]} + {16'd0, rbit};
        out_data = '0;
        out_user = 1'b0;
        if (s2.nan) begin
            out_user = 1'b1;
        end else if (s2.ovf) begin
            out_user = 1'b1;
            out_data = s2.sign ? 16'h8000 : 16'h7FFF;
        end else if (!s2.sign) begin
            if (rmag > 17'd32767) begin
                out_user = 1'b1;
                out_data = 16'h7FFF;
            end else begin
                out_data = rmag[15:0];
            end
        end else begin
            if (rmag > 17'd32768) begin
                out_user = 1'b1;
                out_data = 16'h8000;
            end else begin
                out_data = 16'(17'd0 - rmag);  // 32768 lands exactly on 0x8000
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe            <= '0;
            m_axis_result_tdata <= '0;
            m_axis_result_tuser <= 1'b0;
        end else if (adv) begin
            vld_pipe            <= {vld_pipe[STAGES-1:1], in_fire};
            s1                  <= s1_d;
            s2                  <= s2_d;
            m_axis_result_tdata <= out_data;
            m_axis_result_tuser <= out_user;
        end
    end

endmodule

// File: tb/tb_float_to_fixed.sv
// Bench for float_to_fixed: two instances (FRAC_BITS 0 and 8) share one input
// stream. Accepted samples go into a queue with their expected outputs computed
// from real arithmetic; one negedge process checks handshake, hold-on-stall,
// reset behaviour, data/order and latency.
module tb_float_to_fixed;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        m_tready = 1'b1;
    logic        s_tready0, s_tready8, m_tvalid0, m_tvalid8, m_tuser0, m_tuser8;
    logic [15:0] m_tdata0, m_tdata8;

    always #5 clk = ~clk;

    float_to_fixed #(.FRAC_BITS(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_a_tvalid(s_tvalid), .s_axis_a_tready(s_tready0), .s_axis_a_tdata(s_tdata),
        .m_axis_result_tvalid(m_tvalid0), .m_axis_result_tready(m_tready),
        .m_axis_result_tdata(m_tdata0), .m_axis_result_tuser(m_tuser0));

    float_to_fixed #(.FRAC_BITS(8)) dut8 (
        .clk(clk), .rst(rst),
        .s_axis_a_tvalid(s_tvalid), .s_axis_a_tready(s_tready8), .s_axis_a_tdata(s_tdata),
        .m_axis_result_tvalid(m_tvalid8), .m_axis_result_tready(m_tready),
        .m_axis_result_tdata(m_tdata8), .m_axis_result_tuser(m_tuser8));

`ifdef F2X_ROUND_EN
    localparam logic [16:0] L_P25  = {1'b0, 16'h0003};
    localparam logic [16:0] L_N25  = {1'b0, 16'hFFFD};
    localparam logic [16:0] L_P15  = {1'b0, 16'h0002};
    localparam logic [16:0] L_HALF = {1'b1, 16'h7FFF};
`else
    localparam logic [16:0] L_P25  = {1'b0, 16'h0002};
    localparam logic [16:0] L_N25  = {1'b0, 16'hFFFE};
    localparam logic [16:0] L_P15  = {1'b0, 16'h0001};
    localparam logic [16:0] L_HALF = {1'b0, 16'h7FFF};
`endif

    typedef struct {
        logic [16:0] exp0, exp8;   // {tuser, tdata}
        bit          l0e, l8e, lat;
        logic [16:0] l0, l8;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0, errors = 0, cyc = 0;
    bit          rst_seen = 1'b0, hold_prev = 1'b0, tmo = 1'b0, tmo_seen = 1'b0, done = 1'b0;
    logic [16:0] prev0, prev8;
    bit          t_l0e = 1'b0, t_l8e = 1'b0, t_lat = 1'b0;
    logic [16:0] t_l0 = '0, t_l8 = '0;

    function automatic real pow2(int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r * 0.5;
        return r;
    endfunction

    // Reference: value * 2^frac, rounded per build, clamped to int16.
    function automatic logic [16:0] model(logic [31:0] f, int frac);
        int  e = int'(f[30:23]);
        int  m;
        real mag, r;
        int  ri;
        if (e == 255) return (f[22:0] != 0) ? {1'b1, 16'h0000} : {1'b1, f[31] ? 16'h8000 : 16'h7FFF};
        if (e == 0) return 17'h0;
        m   = int'({8'h0, 1'b1, f[22:0]});
        mag = $itor(m) * pow2(e - 150 + frac);
`ifdef F2X_ROUND_EN
        r = $floor(mag + 0.5);
`else
        r = $floor(mag);
`endif
        if (!f[31]) begin
            if (r > 32767.0) return {1'b1, 16'h7FFF};
            ri = int'(r);
            return {1'b0, 16'(ri)};
        end
        if (r > 32768.0) return {1'b1, 16'h8000};
        ri = int'(r);
        return {1'b0, 16'(-ri)};
    endfunction

    function automatic logic [31:0] int2float(int n);
        int          msb = 0;
        logic [31:0] m;
        for (int i = 0; i < 31; i++) if (((n >> i) & 1) == 1) msb = i;
        m = 32'(n) << (23 - msb);
        return {1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_float();
        int          sel = int'($urandom_range(0, 19));
        logic [7:0]  e;
        logic [22:0] m = 23'($urandom);
        if (sel == 0)      begin e = 8'd0; m = '0; end
        else if (sel == 1) e = 8'd255;
        else if (sel == 2) e = 8'd0;
        else if (sel == 3) m = '0;
        else               e = 8'($urandom_range(110, 150));
        if (sel == 3) e = 8'($urandom_range(120, 145));
        return {1'($urandom), e, m};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst_seen) begin
            chk("reset_out0", 32'({m_tvalid0, m_tuser0, m_tdata0}), 32'h0);
            chk("reset_out8", 32'({m_tvalid8, m_tuser8, m_tdata8}), 32'h0);
            chk("reset_tready", 32'(s_tready0), 32'h1);
        end
        chk("tready0", 32'(s_tready0), 32'(!m_tvalid0 || m_tready));
        chk("tready8", 32'(s_tready8), 32'(!m_tvalid8 || m_tready));
        if (hold_prev) begin
            chk("hold0", 32'({m_tvalid0, m_tuser0, m_tdata0}), 32'({1'b1, prev0}));
            chk("hold8", 32'({m_tvalid8, m_tuser8, m_tdata8}), 32'({1'b1, prev8}));
        end
        if (m_tvalid0 && m_tready) begin
            if (q.size() == 0) chk("phantom_output", 32'h1, 32'h0);
            else begin
                e = q.pop_front();
                chk("data0", 32'({m_tuser0, m_tdata0}), 32'(e.exp0));
                chk("data8", 32'({m_tvalid8, m_tuser8, m_tdata8}), 32'({1'b1, e.exp8}));
                if (e.l0e) chk("model_pin0", 32'(e.exp0), 32'(e.l0));
                if (e.l8e) chk("model_pin8", 32'(e.exp8), 32'(e.l8));
                if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
            end
        end
        hold_prev = m_tvalid0 && !m_tready && !rst;
        prev0     = {m_tuser0, m_tdata0};
        prev8     = {m_tuser8, m_tdata8};
        if (rst) q.delete();
        else if (s_tvalid && s_tready0)
            q.push_back('{model(s_tdata, 0), model(s_tdata, 8), t_l0e, t_l8e, t_lat, t_l0, t_l8, cyc});
        rst_seen = rst;
        if (tmo && !tmo_seen) begin
            chk("timeout", 32'h1, 32'h0);
            tmo_seen = 1'b1;
        end
    end

    task automatic send(input logic [31:0] d, input bit l0e, input logic [16:0] l0,
                        input bit l8e, input logic [16:0] l8, input bit lat);
        bit acc;
        s_tvalid = 1'b1; s_tdata = d;
        t_l0e = l0e; t_l0 = l0; t_l8e = l8e; t_l8 = l8; t_lat = lat;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk); acc = s_tready0;
            @(posedge clk); #1;
            if (acc) break;
            if (n == 199) tmo = 1'b1;
        end
        s_tvalid = 1'b0; t_l0e = 1'b0; t_l8e = 1'b0; t_lat = 1'b0;
    endtask

    task automatic drain();
        m_tready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (q.size() != 0) tmo = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed values with hand-computed results
        send(32'h3F800000, 1, {1'b0, 16'h0001}, 1, {1'b0, 16'h0100}, 1);
        drain();
        send(32'hC2F60000, 1, {1'b0, 16'hFF85}, 0, '0, 1);
        send(32'h47000000, 1, {1'b1, 16'h7FFF}, 1, {1'b1, 16'h7FFF}, 0);
        send(32'hC7000000, 1, {1'b0, 16'h8000}, 1, {1'b1, 16'h8000}, 0);
        send(32'h7F800000, 1, {1'b1, 16'h7FFF}, 1, {1'b1, 16'h7FFF}, 0);
        send(32'hFF800000, 1, {1'b1, 16'h8000}, 0, '0, 0);
        send(32'h7FC00000, 1, {1'b1, 16'h0000}, 1, {1'b1, 16'h0000}, 0);
        send(32'h80000000, 1, {1'b0, 16'h0000}, 1, {1'b0, 16'h0000}, 0);
        send(32'h00400000, 1, {1'b0, 16'h0000}, 1, {1'b0, 16'h0000}, 0);
        send(32'h40200000, 1, L_P25, 1, {1'b0, 16'h0280}, 0);
        send(32'hC0200000, 1, L_N25, 0, '0, 0);
        send(32'h46FFFF00, 1, L_HALF, 0, '0, 0);
        send(32'h3FC00000, 1, L_P15, 1, {1'b0, 16'h0180}, 0);
        send(32'hBE800000, 0, '0, 1, {1'b0, 16'hFFC0}, 0);
        send(32'h43000000, 1, {1'b0, 16'h0080}, 1, {1'b1, 16'h7FFF}, 0);
        drain();

        // Reset with three samples in flight and the output stalled
        send(32'h3F800000, 0, '0, 0, '0, 0);
        send(32'h40000000, 0, '0, 0, '0, 0);
        send(32'h40400000, 0, '0, 0, '0, 0);
        m_tready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; m_tready = 1'b1;
        send(32'h40800000, 1, {1'b0, 16'h0004}, 1, {1'b0, 16'h0400}, 1);
        drain();

        // Ramp 1..20 with a five-cycle downstream stall
        fork
            begin
                for (int i = 1; i <= 20; i++)
                    send(int2float(i), 1, {1'b0, 16'(i)}, 1, {1'b0, 16'(i * 256)}, 0);
            end
            begin
                repeat (8) @(posedge clk);
                #1 m_tready = 1'b0;
                repeat (5) @(posedge clk);
                #1 m_tready = 1'b1;
            end
        join
        drain();

        // Random samples, random gaps, random backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 2)) @(posedge clk);
                        #1;
                    end
                    send(rand_float(), 0, '0, 0, '0, 0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_tready = ($urandom_range(0, 3) != 0);
                end
                m_tready = 1'b1;
            end
        join
        drain();

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/float_to_fixed.md
FLOAT_TO_FIXED -- requirements
Module: float_to_fixed

Interface
REQ-001 The block SHALL have parameter FRAC_BITS, default 0: number of fractional bits in the 16-bit signed output, legal range 0..15.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port s_axis_a_tvalid, input, 1 bit: input sample valid.
REQ-005 The block SHALL have port s_axis_a_tready, output, 1 bit: block accepts an input sample this cycle.
REQ-006 The block SHALL have port s_axis_a_tdata, input, 32 bits: IEEE-754 single-precision sample.
REQ-007 The block SHALL have port m_axis_result_tvalid, output, 1 bit: output sample valid.
REQ-008 The block SHALL have port m_axis_result_tready, input, 1 bit: downstream accepts the output sample.
REQ-009 The block SHALL have port m_axis_result_tdata, output, 16 bits: two's-complement fixed-point result, Q(15-FRAC_BITS).FRAC_BITS.
REQ-010 The block SHALL have port m_axis_result_tuser, output, 1 bit: saturation/invalid flag for the sample on tdata.

Function
REQ-011 The block SHALL implement a 3-stage pipeline: S1 unpack/classify (sign, exponent, mantissa with hidden bit, NaN/Inf/zero/denormal), S2 shift mantissa by (exponent - 127 + FRAC_BITS), S3 round, saturate, negate.
REQ-012 Latency SHALL be exactly 3 clk cycles from input handshake to m_axis_result_tvalid with m_axis_result_tready held high; throughput one sample per cycle.
REQ-013 The pipeline SHALL advance when (!m_axis_result_tvalid || m_axis_result_tready); s_axis_a_tready SHALL equal that condition, combinationally.
REQ-014 While stalled, m_axis_result_tdata, m_axis_result_tuser and all stage registers SHALL hold; no sample SHALL be lost, duplicated or reordered.
REQ-015 An input is accepted only on s_axis_a_tvalid && s_axis_a_tready; a stage bubble SHALL propagate as valid=0.
REQ-016 Zero, negative zero and denormal inputs SHALL produce 0x0000, tuser=0.
REQ-017 NaN input SHALL produce 0x0000, tuser=1.
REQ-018 +Inf and any positive result above 32767 LSB SHALL produce 0x7FFF, tuser=1; -Inf and any negative result below -32768 LSB SHALL produce 0x8000, tuser=1.
REQ-019 Exactly -32768 LSB SHALL produce 0x8000 with tuser=0.
REQ-020 Saturation SHALL be evaluated after rounding (e.g. 32767.5 rounding to 32768 saturates to 0x7FFF, tuser=1).
REQ-021 Right shifts of 24 or more bits SHALL yield magnitude 0 (before rounding); left shifts that would exceed 16 magnitude bits SHALL saturate, never wrap.

Reset
REQ-022 When rst=1 at a clock edge, all stage valid bits and m_axis_result_tvalid SHALL clear to 0, m_axis_result_tdata to 0x0000, m_axis_result_tuser to 0.
REQ-023 Reset mid-stream SHALL discard all in-flight samples; s_axis_a_tready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-024 Macro F2X_ROUND_EN SHALL select rounding: defined -> round to nearest, ties away from zero; undefined -> truncate toward zero (discard fractional bits of magnitude).
REQ-025 Latency, handshake and saturation rules SHALL be identical with and without F2X_ROUND_EN.

Verification
REQ-026 FRAC_BITS=0, m_axis_result_tready=1: input 0x3F800000 (1.0) -> 0x0001, tuser=0, exactly 3 cycles later; 0xC2F60000 (-123.0) -> 0xFF85, tuser=0.
REQ-027 FRAC_BITS=0: 0x47000000 (32768.0) -> 0x7FFF, tuser=1; 0xC7000000 (-32768.0) -> 0x8000, tuser=0; 0x7F800000 (+Inf) -> 0x7FFF, tuser=1; 0x7FC00000 (NaN) -> 0x0000, tuser=1; 0x80000000 (-0) -> 0x0000, tuser=0.
REQ-028 FRAC_BITS=0: 0x40200000 (2.5) -> 0x0003 with F2X_ROUND_EN, 0x0002 without; 0xC0200000 (-2.5) -> 0xFFFD with, 0xFFFE without.
REQ-029 FRAC_BITS=8: 0x3FC00000 (1.5) -> 0x0180; 0xBE800000 (-0.25) -> 0xFFC0; 0x43000000 (128.0) -> 0x7FFF, tuser=1.
REQ-030 Continuous valid input of ramp 1.0..20.0, m_axis_result_tready low for 5 cycles mid-stream -> s_axis_a_tready low during stall, all 20 outputs 0x0001..0x0014 in order, none lost or repeated.
REQ-031 rst pulsed 1 cycle with 3 samples in flight -> m_axis_result_tvalid=0 next cycle, none of those samples ever emitted, next input emerges 3 cycles after acceptance.
